// File: rtl/ast_width_reducer_pkg.sv
// Shared types and beat-geometry helpers for the Avalon-ST width reducer.
// The helper functions work on byte counts so any width pairing can use them.
package ast_wr_package;

  localparam int DEF_DATA_IN_W  = 256;
  localparam int DEF_DATA_OUT_W = 64;
  localparam int DEF_CHANNEL_W  = 10;
  localparam int RATIO          = DEF_DATA_IN_W / DEF_DATA_OUT_W;
  localparam int BYTES_OUT      = DEF_DATA_OUT_W / 8;

  typedef enum logic [2:0] {
    TC_RESET,
    TC_FULL_BEAT,
    TC_PARTIAL,
    TC_ONE_WORD,
    TC_STALL,
    TC_BACK2BACK,
    TC_RESET_ABORT,
    TC_RANDOM
  } test_case_e;

  typedef enum logic {
    ST_IDLE,
    ST_SEND
  } state_e;

  // Index of the final narrow word holding at least one valid byte.
  function automatic int calc_last_idx(int empty_in, int bytes_in, int bytes_out);
    int valid_bytes;
    valid_bytes = bytes_in - empty_in;
    if (valid_bytes < 1) valid_bytes = 1;
    return (valid_bytes + bytes_out - 1) / bytes_out - 1;
  endfunction

  function automatic int calc_empty_out(int empty_in, int bytes_in, int bytes_out);
    int valid_bytes;
    valid_bytes = bytes_in - empty_in;
    if (valid_bytes < 1) valid_bytes = 1;
    return (calc_last_idx(empty_in, bytes_in, bytes_out) + 1) * bytes_out - valid_bytes;
  endfunction

endpackage

// File: rtl/ast_width_reducer.sv
// Avalon-ST down-converter: one wide beat is held and replayed as narrow words,
// word 0 first, trimming trailing all-empty words on the end-of-packet beat.
module ast_width_reducer
  import ast_wr_package::*;
#(
  parameter int DATA_IN_W   = DEF_DATA_IN_W,
  parameter int EMPTY_IN_W  = ($clog2(DATA_IN_W / 8) == 0) ? 1 : $clog2(DATA_IN_W / 8),
  parameter int CHANNEL_W   = DEF_CHANNEL_W,
  parameter int DATA_OUT_W  = DEF_DATA_OUT_W,
  parameter int EMPTY_OUT_W = ($clog2(DATA_OUT_W / 8) == 0) ? 1 : $clog2(DATA_OUT_W / 8)
) (
  input  logic                   clk_i,
  input  logic                   arst_i,
  input  logic [DATA_IN_W-1:0]   ast_data_i,
  input  logic                   ast_startofpacket_i,
  input  logic                   ast_endofpacket_i,
  input  logic                   ast_valid_i,
  input  logic [EMPTY_IN_W-1:0]  ast_empty_i,
  input  logic [CHANNEL_W-1:0]   ast_channel_i,
  output logic                   ast_ready_o,
  output logic [DATA_OUT_W-1:0]  ast_data_o,
  output logic                   ast_startofpacket_o,
  output logic                   ast_endofpacket_o,
  output logic                   ast_valid_o,
  output logic [EMPTY_OUT_W-1:0] ast_empty_o,
  output logic [CHANNEL_W-1:0]   ast_channel_o,
  input  logic                   ast_ready_i
);

  localparam int R        = DATA_IN_W / DATA_OUT_W;
  localparam int BYTES_IN = DATA_IN_W / 8;
  localparam int BO       = DATA_OUT_W / 8;
  localparam int IDX_W    = (R > 1) ? $clog2(R) : 1;

  // Handshakes: a sink beat moves when ast_valid_i & ast_ready_o, a narrow word
  // moves when ast_valid_o & ast_ready_i; a stalled source holds every output.
  state_e                       state, state_nxt;
  logic [IDX_W-1:0]             idx, idx_inc, last_idx, last_in;
  logic [R-1:0][DATA_OUT_W-1:0] hold_words;
  logic                         hold_eop;
  logic [EMPTY_OUT_W-1:0]       hold_empty, empty_in_calc;
  logic                         sink_xfer, src_xfer, at_last;

  always_comb begin
    idx_inc       = idx + IDX_W'(1);
    at_last       = (idx == last_idx);
    src_xfer      = ast_valid_o & ast_ready_i;
    ast_ready_o   = 1'b0;
    if (!arst_i) begin
      ast_ready_o = (state == ST_IDLE) | ((state == ST_SEND) & at_last & ast_ready_i);
    end
    sink_xfer     = ast_valid_i & ast_ready_o;
    // A non-eop beat uses empty 0, which yields last = R-1 and empty 0.
    last_in       = IDX_W'(calc_last_idx(ast_endofpacket_i ? int'(ast_empty_i) : 0,
                                         BYTES_IN, BO));
    empty_in_calc = EMPTY_OUT_W'(calc_empty_out(ast_endofpacket_i ? int'(ast_empty_i) : 0,
                                                BYTES_IN, BO));
    state_nxt     = state;
    case (state)
      ST_IDLE: if (sink_xfer) state_nxt = ST_SEND;
      ST_SEND: if (src_xfer && at_last && !sink_xfer) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state               <= ST_IDLE;
      idx                 <= '0;
      last_idx            <= '0;
      hold_words          <= '0;
      hold_eop            <= 1'b0;
      hold_empty          <= '0;
      ast_data_o          <= '0;
      ast_startofpacket_o <= 1'b0;
      ast_endofpacket_o   <= 1'b0;
      ast_valid_o         <= 1'b0;
      ast_empty_o         <= '0;
      ast_channel_o       <= '0;
    end else begin
      state <= state_nxt;
      if (sink_xfer) begin
        hold_words          <= ast_data_i;
        hold_eop            <= ast_endofpacket_i;
        hold_empty          <= empty_in_calc;
        last_idx            <= last_in;
        idx                 <= '0;
        ast_data_o          <= ast_data_i[DATA_OUT_W-1:0];
        ast_startofpacket_o <= ast_startofpacket_i;
        ast_endofpacket_o   <= ast_endofpacket_i & (last_in == '0);
        ast_empty_o         <= (ast_endofpacket_i && last_in == '0) ? empty_in_calc : '0;
        ast_channel_o       <= ast_channel_i;
        ast_valid_o         <= 1'b1;
      end else if (src_xfer) begin
        ast_startofpacket_o <= 1'b0;
        if (at_last) begin
          ast_valid_o       <= 1'b0;
          ast_endofpacket_o <= 1'b0;
          ast_empty_o       <= '0;
        end else begin
          idx               <= idx_inc;
          ast_data_o        <= hold_words[idx_inc];
          ast_endofpacket_o <= hold_eop & (idx_inc == last_idx);
          ast_empty_o       <= (hold_eop && idx_inc == last_idx) ? hold_empty : '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ast_width_reducer.sv
// Randomized and directed bench for ast_width_reducer with a byte-level
// reference model feeding an expected-word queue.
module tb_ast_width_reducer;
  import ast_wr_package::*;

  localparam int DIW = 256;
  localparam int DOW = 64;
  localparam int CW  = 10;
  localparam int EIW = 5;
  localparam int EOW = 3;
  localparam int PW  = DOW + 2 + EOW + CW;

  logic           clk = 1'b0;
  logic           arst_i = 1'b1;
  logic [DIW-1:0] ast_data_i = '0;
  logic           ast_startofpacket_i = 1'b0;
  logic           ast_endofpacket_i = 1'b0;
  logic           ast_valid_i = 1'b0;
  logic [EIW-1:0] ast_empty_i = '0;
  logic [CW-1:0]  ast_channel_i = '0;
  logic           ast_ready_o;
  logic [DOW-1:0] ast_data_o;
  logic           ast_startofpacket_o;
  logic           ast_endofpacket_o;
  logic           ast_valid_o;
  logic [EOW-1:0] ast_empty_o;
  logic [CW-1:0]  ast_channel_o;
  logic           ast_ready_i = 1'b1;

  ast_width_reducer dut (
    .clk_i               (clk),
    .arst_i              (arst_i),
    .ast_data_i          (ast_data_i),
    .ast_startofpacket_i (ast_startofpacket_i),
    .ast_endofpacket_i   (ast_endofpacket_i),
    .ast_valid_i         (ast_valid_i),
    .ast_empty_i         (ast_empty_i),
    .ast_channel_i       (ast_channel_i),
    .ast_ready_o         (ast_ready_o),
    .ast_data_o          (ast_data_o),
    .ast_startofpacket_o (ast_startofpacket_o),
    .ast_endofpacket_o   (ast_endofpacket_o),
    .ast_valid_o         (ast_valid_o),
    .ast_empty_o         (ast_empty_o),
    .ast_channel_o       (ast_channel_o),
    .ast_ready_i         (ast_ready_i)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  test_case_e cur_tc = TC_RESET;
  int         ready_mode = 0;  // 0 always, 1 alternate, 2 random
  int         out_cnt = 0;
  int         run_len = 0;
  int         max_run = 0;
  logic       stall_prev = 1'b0;
  logic [PW-1:0] prev_out = '0;
  logic [PW-1:0] exp_q[$];
  logic [PW-1:0] got_log[$];

  function automatic logic [PW-1:0] pack(logic [DOW-1:0] d, logic s, logic e,
                                         logic [EOW-1:0] em, logic [CW-1:0] ch);
    return {d, s, e, em, ch};
  endfunction

  task automatic check(string tag, logic [PW-1:0] got, logic [PW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s [%s] got=%h exp=%h", tag, cur_tc.name(), got, exp);
    end
  endtask

  // Reference: count valid bytes, split into 8-byte words, drop words past the last valid byte.
  task automatic model_push(logic [DIW-1:0] d, logic s, logic e, logic [EIW-1:0] em,
                            logic [CW-1:0] ch);
    int nbytes, nwords, pad;
    logic is_last;
    nbytes = DIW / 8 - (e ? int'(em) : 0);
    nwords = (nbytes + 7) / 8;
    for (int k = 0; k < nwords; k++) begin
      is_last = e && (k == nwords - 1);
      pad = is_last ? nwords * 8 - nbytes : 0;
      exp_q.push_back(pack(d[k*DOW +: DOW], s && (k == 0), is_last, EOW'(pad), ch));
    end
  endtask

  // ---------------- ready driver ----------------
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       ast_ready_i = 1'b1;
      1:       ast_ready_i = ~ast_ready_i;
      default: ast_ready_i = ($urandom_range(0, 3) != 0);
    endcase
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [PW-1:0] cur;
    if (arst_i) begin
      stall_prev = 1'b0;
      run_len    = 0;
    end else begin
      cur = pack(ast_data_o, ast_startofpacket_o, ast_endofpacket_o, ast_empty_o, ast_channel_o);
      if (stall_prev) check("stall_hold", cur, prev_out);
      run_len = ast_valid_o ? run_len + 1 : 0;
      if (run_len > max_run) max_run = run_len;
      if (ast_valid_i && ast_ready_o)
        model_push(ast_data_i, ast_startofpacket_i, ast_endofpacket_i, ast_empty_i, ast_channel_i);
      if (ast_valid_o && ast_ready_i) begin
        check("word_expected", PW'(exp_q.size() != 0), PW'(1));
        if (exp_q.size() != 0) check("out_word", cur, exp_q.pop_front());
        got_log.push_back(cur);
        out_cnt++;
      end
      stall_prev = ast_valid_o && !ast_ready_i;
      prev_out   = cur;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_beat(logic [DIW-1:0] d, logic s, logic e, logic [EIW-1:0] em,
                           logic [CW-1:0] ch);
    logic accepted;
    accepted            = 1'b0;
    ast_data_i          = d;
    ast_startofpacket_i = s;
    ast_endofpacket_i   = e;
    ast_empty_i         = em;
    ast_channel_i       = ch;
    ast_valid_i         = 1'b1;
    for (int c = 0; c < 200 && !accepted; c++) begin
      @(negedge clk);
      accepted = ast_ready_o;
      @(posedge clk);
      #1;
    end
    check("sink_accepted", PW'(accepted), PW'(1));
    ast_valid_i = 1'b0;
  endtask

  task automatic wait_drain();
    for (int c = 0; c < 2000; c++) begin
      @(posedge clk);
      if (exp_q.size() == 0 && !ast_valid_o) break;
    end
    #1;
    check("drained", PW'(exp_q.size()), PW'(0));
  endtask

  function automatic logic [DIW-1:0] rand_data();
    logic [DIW-1:0] d;
    for (int i = 0; i < DIW / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    logic [DIW-1:0] d;
    int base, nb, gap;
    logic [CW-1:0] ch;

    cur_tc = TC_RESET;
    ast_valid_i = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_outputs", pack(ast_data_o, ast_startofpacket_o, ast_endofpacket_o,
                              ast_empty_o, ast_channel_o), '0);
    check("rst_valid", PW'(ast_valid_o), PW'(0));
    check("rst_ready", PW'(ast_ready_o), PW'(0));
    ast_valid_i = 1'b0;
    arst_i = 1'b0;
    @(negedge clk);
    check("idle_ready", PW'(ast_ready_o), PW'(1));
    @(posedge clk); #1;

    cur_tc = TC_FULL_BEAT;
    for (int i = 0; i < 32; i++) d[i*8 +: 8] = 8'(i);
    got_log.delete();
    send_beat(d, 1'b1, 1'b1, 5'd0, 10'h005);
    wait_drain();
    check("t1_count", PW'(got_log.size()), PW'(4));
    if (got_log.size() == 4) begin
      check("t1_word0", PW'(got_log[0][PW-1 -: DOW]), PW'(64'h0706050403020100));
      check("t1_word3", PW'(got_log[3][PW-1 -: DOW]), PW'(64'h1F1E1D1C1B1A1918));
      check("t1_sop_first", PW'(got_log[0][CW+EOW+1]), PW'(1));
      check("t1_eop_last", PW'(got_log[3][CW+EOW]), PW'(1));
    end

    cur_tc = TC_PARTIAL;
    got_log.delete();
    send_beat(rand_data(), 1'b1, 1'b1, 5'd20, 10'h033);
    wait_drain();
    check("t2_count", PW'(got_log.size()), PW'(2));
    if (got_log.size() == 2) begin
      check("t2_eop", PW'(got_log[1][CW+EOW]), PW'(1));
      check("t2_empty", PW'(got_log[1][CW +: EOW]), PW'(4));
    end

    cur_tc = TC_ONE_WORD;
    got_log.delete();
    send_beat(rand_data(), 1'b1, 1'b1, 5'd31, 10'h100);
    @(negedge clk);
    check("t3_ready_back", PW'(ast_ready_o), PW'(1));
    wait_drain();
    check("t3_count", PW'(got_log.size()), PW'(1));
    if (got_log.size() == 1) begin
      check("t3_flags", PW'(got_log[0][CW +: EOW+2]), PW'({1'b1, 1'b1, 3'd7}));
    end

    cur_tc = TC_STALL;
    ready_mode = 1;
    got_log.delete();
    for (int b = 0; b < 3; b++) send_beat(rand_data(), b == 0, b == 2, 5'd0, 10'h2A1);
    wait_drain();
    check("t4_count", PW'(got_log.size()), PW'(12));
    ready_mode = 0;
    repeat (2) @(posedge clk);
    #1;

    cur_tc = TC_BACK2BACK;
    got_log.delete();
    max_run = 0;
    for (int p = 0; p < 2; p++)
      for (int b = 0; b < 2; b++) send_beat(rand_data(), b == 0, b == 1, 5'd0, CW'(p + 7));
    wait_drain();
    check("t5_count", PW'(got_log.size()), PW'(16));
    check("t5_valid_run", PW'(max_run), PW'(16));

    cur_tc = TC_RESET_ABORT;
    base = out_cnt;
    send_beat(rand_data(), 1'b1, 1'b0, 5'd0, 10'h155);
    for (int c = 0; c < 50 && out_cnt < base + 2; c++) @(posedge clk);
    check("t6_two_words", PW'(out_cnt - base), PW'(2));
    #2 arst_i = 1'b1;
    #1;
    check("t6_valid_low", PW'(ast_valid_o), PW'(0));
    check("t6_ready_low", PW'(ast_ready_o), PW'(0));
    @(negedge clk);
    exp_q.delete();
    @(negedge clk);
    arst_i = 1'b0;
    got_log.delete();
    @(posedge clk); #1;
    send_beat(rand_data(), 1'b1, 1'b1, 5'd8, 10'h0AA);
    wait_drain();
    check("t6_count", PW'(got_log.size()), PW'(3));
    if (got_log.size() != 0) check("t6_sop_word0", PW'(got_log[0][CW+EOW+1]), PW'(1));

    cur_tc = TC_RANDOM;
    ready_mode = 2;
    for (int p = 0; p < 25; p++) begin
      nb = $urandom_range(1, 3);
      ch = CW'($urandom);
      for (int b = 0; b < nb; b++) begin
        send_beat(rand_data(), b == 0, b == nb - 1, EIW'($urandom_range(0, 31)), ch);
        gap = $urandom_range(0, 2);
        repeat (gap) @(posedge clk);
        if (gap != 0) #1;
      end
    end
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
